// File: rtl/mmio_uart_tx_pkg.sv
// Shared UART register map: tangle_config defines (offsets, STATUS bits, base address)
// plus typed package constants and the STATUS word packer.
`ifndef TANGLE_CONFIG_DEFS
`define TANGLE_CONFIG_DEFS
`define TANGLE_UART_OFF_TXDATA  2'd0
`define TANGLE_UART_OFF_STATUS  2'd1
`define TANGLE_UART_OFF_DIVISOR 2'd2
`define TANGLE_UART_OFF_IRQ_EN  2'd3
`define TANGLE_UART_STAT_FULL   0
`define TANGLE_UART_STAT_EMPTY  1
`define TANGLE_UART_STAT_BUSY   2
`define TANGLE_UART_STAT_OVF    3
`define TANGLE_UART_BASE        16'hFF00
`endif

package mmio_uart_tx_pkg;

  localparam logic [1:0] OFF_TXDATA  = `TANGLE_UART_OFF_TXDATA;
  localparam logic [1:0] OFF_STATUS  = `TANGLE_UART_OFF_STATUS;
  localparam logic [1:0] OFF_DIVISOR = `TANGLE_UART_OFF_DIVISOR;
  localparam logic [1:0] OFF_IRQ_EN  = `TANGLE_UART_OFF_IRQ_EN;

  localparam int STAT_FULL  = `TANGLE_UART_STAT_FULL;
  localparam int STAT_EMPTY = `TANGLE_UART_STAT_EMPTY;
  localparam int STAT_BUSY  = `TANGLE_UART_STAT_BUSY;
  localparam int STAT_OVF   = `TANGLE_UART_STAT_OVF;

  localparam logic [15:0] UART_BASE_DEFAULT = `TANGLE_UART_BASE;

  function automatic logic [15:0] pack_status(input logic full, input logic empty,
                                              input logic busy, input logic ovf,
                                              input logic [4:0] count);
    logic [15:0] s;
    s             = '0;
    s[STAT_FULL]  = full;
    s[STAT_EMPTY] = empty;
    s[STAT_BUSY]  = busy;
    s[STAT_OVF]   = ovf;
    s[12:8]       = count;
    return s;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock show-ahead FIFO; a push while full is discarded even if a pop
// happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU data bus (4-word window).
// Optional MMIO_UART_IRQ_EN adds the IRQ_EN register at offset 3 and drives irq_o.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | line high, waiting for a byte in the FIFO
// ST_START | start bit (low) for div_lat cycles
// ST_DATA  | 8 data bits LSB first, bit_cnt 0..7
// ST_STOP  | stop bit (high); chains straight into next START
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = UART_BASE_DEFAULT,
  parameter int          FIFO_DEPTH = 4,
  parameter int          DIV_RESET  = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] addr_i,
  input  logic [15:0] data_i,
  input  logic        we_i,
  output logic [15:0] data_o,
  output logic        hit_o,
  output logic        tx_o,
  output logic        irq_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;
  localparam int         CW       = $clog2(FIFO_DEPTH) + 1;

  logic          hit;
  logic [1:0]    off;
  logic          wr;
  logic          push;
  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  logic [1:0]    state;
  logic [15:0]   baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [15:0]   div_lat;
  logic [15:0]   divisor;
  logic          ovf;
  logic          busy;
  logic [15:0]   status;
  logic [15:0]   rd_mux;

  assign hit    = (addr_i[15:2] == BASE_ADDR[15:2]);
  assign off    = addr_i[1:0];
  assign wr     = we_i && hit;
  assign push   = wr && (off == OFF_TXDATA);
  assign busy   = (state != ST_IDLE);
  assign status = pack_status(fifo_full, fifo_empty, busy, ovf, 5'(fifo_count));

  // Pops only at a frame boundary: from IDLE, or at the final cycle of STOP.
  assign fifo_pop = !fifo_empty &&
                    ((state == ST_IDLE) || ((state == ST_STOP) && (baud_cnt == '0)));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .din   (data_i[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef MMIO_UART_IRQ_EN
  logic irq_en;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_en <= 1'b0;
      irq_o  <= 1'b0;
    end else begin
      if (wr && (off == OFF_IRQ_EN)) irq_en <= data_i[0];
      irq_o <= irq_en && fifo_empty && !busy;
    end
  end
`else
  assign irq_o = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_TXDATA:  rd_mux = status;
      OFF_STATUS:  rd_mux = status;
      OFF_DIVISOR: rd_mux = divisor;
`ifdef MMIO_UART_IRQ_EN
      OFF_IRQ_EN:  rd_mux = {15'd0, irq_en};
`endif
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o  <= '0;
      hit_o   <= 1'b0;
      divisor <= 16'(DIV_RESET);
      ovf     <= 1'b0;
    end else begin
      hit_o  <= hit;
      data_o <= hit ? rd_mux : 16'd0;
      if (push && fifo_full)
        ovf <= 1'b1;
      else if (wr && (off == OFF_STATUS) && data_i[STAT_OVF])
        ovf <= 1'b0;
      if (wr && (off == OFF_DIVISOR))
        divisor <= (data_i == 16'd0) ? 16'd1 : data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      tx_o     <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      div_lat  <= 16'(DIV_RESET);
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            shreg    <= fifo_dout;
            div_lat  <= divisor;
            baud_cnt <= divisor - 16'd1;
            tx_o     <= 1'b0;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (baud_cnt == '0) begin
            baud_cnt <= div_lat - 16'd1;
            bit_cnt  <= '0;
            tx_o     <= shreg[0];
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (baud_cnt == '0) begin
            baud_cnt <= div_lat - 16'd1;
            if (bit_cnt == 3'd7) begin
              tx_o  <= 1'b1;
              state <= ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              tx_o    <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        ST_STOP: begin
          if (baud_cnt == '0) begin
            if (!fifo_empty) begin
              shreg    <= fifo_dout;
              div_lat  <= divisor;
              baud_cnt <= divisor - 16'd1;
              tx_o     <= 1'b0;
              state    <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          tx_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register access, frame timing, FIFO overflow,
// divisor edge case and mid-frame reset; IRQ checks when MMIO_UART_IRQ_EN is set.
module tb_mmio_uart_tx;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] addr_i = '0;
  logic [15:0] data_i = '0;
  logic        we_i = 1'b0;
  logic [15:0] data_o;
  logic        hit_o;
  logic        tx_o;
  logic        irq_o;

  int n_checks = 0;
  int n_errors = 0;
  logic cap [0:255];

  mmio_uart_tx dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .addr_i (addr_i),
    .data_i (data_i),
    .we_i   (we_i),
    .data_o (data_o),
    .hit_o  (hit_o),
    .tx_o   (tx_o),
    .irq_o  (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk_i);
    addr_i = a; data_i = d; we_i = 1'b1;
    @(posedge clk_i);
    #1 we_i = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d, output logic h);
    @(negedge clk_i);
    addr_i = a; we_i = 1'b0;
    @(posedge clk_i);
    #1 d = data_o; h = hit_o;
  endtask

  // First sample is the line state after the edge following the call.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #2 cap[i] = tx_o;
    end
  endtask

  function automatic logic [63:0] exp_frame(input logic [7:0] b, input int d);
    logic [63:0] v;
    int j;
    v = '0;
    for (int i = 0; i < 10 * d; i++) begin
      j = i / d;
      if (j == 0)      v[i] = 1'b0;
      else if (j == 9) v[i] = 1'b1;
      else             v[i] = b[j-1];
    end
    return v;
  endfunction

  task automatic cmp_frame(input string tag, input int base, input logic [7:0] b, input int d);
    logic [63:0] g;
    g = '0;
    for (int i = 0; i < 10 * d; i++) g[i] = cap[base+i];
    check_eq(tag, g, exp_frame(b, d));
  endtask

  task automatic cmp_idle(input string tag, input int base, input int n);
    logic [63:0] g;
    logic [63:0] e;
    g = '0; e = '0;
    for (int i = 0; i < n; i++) begin
      g[i] = cap[base+i];
      e[i] = 1'b1;
    end
    check_eq(tag, g, e);
  endtask

  logic [15:0] rd;
  logic        rh;
  int          irq_hi;

  initial begin
    // reset and idle
    repeat (3) @(posedge clk_i);
    #1;
    check_eq("rst_tx", tx_o, 1);
    check_eq("rst_irq", irq_o, 0);
    check_eq("rst_data", data_o, 0);
    check_eq("rst_hit", hit_o, 0);
    @(negedge clk_i) rst_i = 1'b0;
    repeat (20) @(posedge clk_i);
    #1;
    check_eq("idle_tx", tx_o, 1);
    check_eq("idle_irq", irq_o, 0);
    bus_read(16'hFF01, rd, rh);
    check_eq("idle_status", rd, 16'h0002);
    check_eq("idle_hit", rh, 1);
    bus_read(16'hFF00, rd, rh);
    check_eq("txdata_rd_status", rd, 16'h0002);
    bus_read(16'hFF02, rd, rh);
    check_eq("div_reset", rd, 16'd16);
    bus_read(16'hFF04, rd, rh);
    check_eq("miss_data", rd, 0);
    check_eq("miss_hit", rh, 0);
    bus_write(16'hFF04, 16'h00AA);
    bus_read(16'hFF01, rd, rh);
    check_eq("miss_write_status", rd, 16'h0002);
`ifndef MMIO_UART_IRQ_EN
    bus_write(16'hFF03, 16'hFFFF);
    bus_read(16'hFF03, rd, rh);
    check_eq("reserved_rd", rd, 0);
`endif

    // single frame, DIV=4, high byte ignored
    bus_write(16'hFF02, 16'd4);
    bus_read(16'hFF02, rd, rh);
    check_eq("div4_rb", rd, 16'd4);
    bus_write(16'hFF00, 16'h1255);
    capture(44);
    cmp_frame("frame_55", 0, 8'h55, 4);
    cmp_idle("frame_55_after", 40, 4);

    // count and busy timing around the first pop
    bus_write(16'hFF00, 16'h00A3);
    bus_read(16'hFF01, rd, rh);
    check_eq("status_n1", rd, 16'h0100);
    bus_read(16'hFF01, rd, rh);
    check_eq("status_n2", rd, 16'h0006);
    repeat (45) @(posedge clk_i);
    bus_read(16'hFF01, rd, rh);
    check_eq("status_done", rd, 16'h0002);

    // five back-to-back bytes, sixth dropped, ovf clear
    bus_write(16'hFF00, 16'h0011);
    fork
      capture(205);
      begin
        bus_write(16'hFF00, 16'h0022);
        bus_write(16'hFF00, 16'h0033);
        bus_write(16'hFF00, 16'h0044);
        bus_write(16'hFF00, 16'h0055);
        bus_write(16'hFF00, 16'h0066);
        bus_read(16'hFF01, rd, rh);
        check_eq("ovf_status", rd, 16'h040D);
        bus_write(16'hFF01, 16'h0008);
        bus_read(16'hFF01, rd, rh);
        check_eq("ovf_cleared", rd, 16'h0405);
      end
    join
    cmp_frame("b2b_f0", 0, 8'h11, 4);
    cmp_frame("b2b_f1", 40, 8'h22, 4);
    cmp_frame("b2b_f2", 80, 8'h33, 4);
    cmp_frame("b2b_f3", 120, 8'h44, 4);
    cmp_frame("b2b_f4", 160, 8'h55, 4);
    cmp_idle("b2b_after", 200, 5);
    bus_read(16'hFF01, rd, rh);
    check_eq("b2b_status", rd, 16'h0002);

    // divisor 0 stored as 1
    bus_write(16'hFF02, 16'd0);
    bus_read(16'hFF02, rd, rh);
    check_eq("div0_rb", rd, 16'd1);
    bus_write(16'hFF00, 16'h000F);
    capture(12);
    cmp_frame("frame_div1", 0, 8'h0F, 1);
    cmp_idle("frame_div1_after", 10, 2);

    // reset mid data bit
    bus_write(16'hFF02, 16'd4);
    bus_write(16'hFF00, 16'h0000);
    bus_write(16'hFF00, 16'h0000);
    repeat (10) @(posedge clk_i);
    #1 check_eq("pre_rst_tx", tx_o, 0);
    @(negedge clk_i) rst_i = 1'b1;
    @(posedge clk_i);
    #1 check_eq("rst_mid_tx", tx_o, 1);
    @(negedge clk_i) rst_i = 1'b0;
    bus_read(16'hFF01, rd, rh);
    check_eq("rst_mid_status", rd, 16'h0002);
    bus_read(16'hFF02, rd, rh);
    check_eq("rst_mid_div", rd, 16'd16);
    capture(20);
    cmp_idle("rst_mid_line", 0, 20);

`ifdef MMIO_UART_IRQ_EN
    bus_write(16'hFF03, 16'h0001);
    bus_read(16'hFF03, rd, rh);
    check_eq("irq_en_rb", rd, 16'h0001);
    check_eq("irq_idle", irq_o, 1);
    bus_write(16'hFF02, 16'd4);
    bus_write(16'hFF00, 16'h005A);
    irq_hi = 0;
    for (int i = 0; i < 41; i++) begin
      @(posedge clk_i);
      #1 if (irq_o) irq_hi++;
    end
    check_eq("irq_busy_cycles", irq_hi, 0);
    @(posedge clk_i);
    #1 check_eq("irq_rise", irq_o, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that sits on the CPU data bus beside the RAM as a second bus responder. It answers CPU stores and loads in a 4-word register window. Bytes written by the CPU enter a small FIFO and are serialized 8N1 on `tx_o` at a programmable divisor. Read data follows the same one-cycle registered latency as the RAM, so the SoC top muxes `data_o`/RAM output using `hit_o`.

## Interface
- `BASE_ADDR`, 16'hFF00: window base; must be 4-word aligned (bits [1:0] = 0).
- `FIFO_DEPTH`, 4: TX FIFO entries; power of two, 2..16.
- `DIV_RESET`, 16: divisor reset value, in clocks per bit.

Ports:
- `clk_i`  in  1  system clock; all logic on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `addr_i`  in  16  CPU bus address (word address).
- `data_i`  in  16  CPU write data.
- `we_i`  in  1  write enable; a write is taken on every edge where `we_i`=1 and the address hits the window.
- `data_o`  out  16  registered read data. Reset value 0.
- `hit_o`  out  1  registered: previous-cycle address was in the window. Reset value 0.
- `tx_o`  out  1  serial line, idle high. Reset value 1.
- `irq_o`  out  1  interrupt. Reset value 0; tied 0 unless the IRQ feature is compiled in.

## Operation
- Address decode: hit = `addr_i[15:2] == BASE_ADDR[15:2]`. Offset = `addr_i[1:0]`.
- Offset 0, TXDATA:
  - Write pushes `data_i[7:0]`; `data_i[15:8]` is ignored.
  - If the FIFO is full at the start of the cycle, the byte is dropped and sticky `ovf` is set. A pop in the same cycle does not make room.
  - Read returns STATUS.
- Offset 1, STATUS (read):
  - bit0 = full, bit1 = empty, bit2 = busy (serializer not IDLE), bit3 = `ovf`.
  - bits[12:8] = FIFO count; other bits 0.
  - Writing 1 to bit3 clears `ovf`; other write bits are ignored.
- Offset 2, DIVISOR (read/write):
  - Width is 16 bits. A written value of 0 is stored as 1.
  - The divisor is latched into the serializer at frame start, so a write mid-frame affects only the next frame.
- Offset 3: IRQ_EN when the IRQ feature is compiled in, otherwise reserved. Reserved reads return 0 and writes are ignored.
- Serializer FSM:
  - IDLE: `tx_o`=1. If the FIFO is non-empty, pop, load the shift register, latch the divisor, and go to START.
  - START: `tx_o`=0 for DIV cycles, then go to DATA.
  - DATA: 8 bits, LSB first, DIV cycles each; a bit counter runs 0..7. After bit 7 go to STOP.
  - STOP: `tx_o`=1 for DIV cycles. At the end, if the FIFO is non-empty, pop and go straight to START (no idle gap); otherwise go to IDLE.
- Baud counter: loads DIV-1 at each bit start and counts down; the bit ends when it reaches 0. A frame is exactly 10·DIV cycles.
- Reset at any time (including mid-frame):
  - FIFO emptied, `ovf`=0, divisor = `DIV_RESET`, IRQ_EN=0.
  - FSM to IDLE; `tx_o`=1 from the reset edge on.

## Timing
- Read latency is 1 cycle: address at edge N, so `data_o`/`hit_o` are valid after edge N+1. `data_o`=0 when there was no hit.
- Write at edge N into an empty FIFO with the FSM idle:
  - Count becomes 1 after N.
  - Pop at N+1; `tx_o` falls after N+1.
  - Busy reads 1 on an address presented from N+1 on.
- Back-to-back frames: the stop bit of frame k is followed directly by the start bit of frame k+1.
- Simultaneous push and pop on a non-full FIFO: both happen and the count is unchanged.
- Count width is log2(FIFO_DEPTH)+1 bits; pointers wrap modulo `FIFO_DEPTH`.

## Configuration
- `MMIO_UART_IRQ_EN`:
  - Defined: offset 3 bit0 is IRQ_EN (read/write). `irq_o` is registered and equals IRQ_EN & empty & !busy, updating one cycle after the condition.
  - Undefined: offset 3 is reserved and `irq_o` is constant 0.

## Structure
- Shared constants belong in `tangle_config.v` as defines:
  - Register offsets (TXDATA, STATUS, DIVISOR, IRQ_EN).
  - STATUS bit indices.
  - Default base address.
- Sub-module `sync_fifo` holds the byte FIFO: parameters WIDTH, DEPTH; ports push, pop, full, empty, count.
- Decode, registers and the serializer FSM stay in `mmio_uart_tx`.

## Test plan
- Reset, then idle 20 cycles → `tx_o`=1, `irq_o`=0; a read of 0xFF01 returns 0x0002 one cycle later with `hit_o`=1.
- Write DIVISOR=4 at 0xFF02, then write 0x1255 at 0xFF00:
  - `tx_o` reads 0 for 4 cycles starting one cycle after the write.
  - Then 1,0,1,0,1,0,1,0, each 4 cycles.
  - Then 1 for 4 cycles: 40 cycles total.
  - High byte ignored.
- With DIV=4, write 5 bytes in 5 consecutive cycles:
  - 1 popped immediately, 4 queued, 0 dropped, so `ovf`=0.
  - A 6th write in the next cycle is dropped and sets STATUS bit3.
  - Writing 0x0008 to 0xFF01 clears it.
  - Five frames are sent back-to-back with no idle cycle.
- Write DIVISOR=0 → readback 1; a frame then lasts 10 cycles.
- Assert `rst_i` for 1 cycle in the middle of a data bit → `tx_o`=1 the next cycle, STATUS=0x0002, DIVISOR reads 16.
- With `MMIO_UART_IRQ_EN`: set IRQ_EN, send one byte → `irq_o`=0 while busy and rises the cycle after the stop bit ends.
